dffssr_pipe: RTL

//  Parametrised successor to the single-bit sync set/reset flop: a DEPTH-stage, WIDTH-bit register pipeline.

---
 rtl/dffssr_pipe_if.sv | 31 +++
 rtl/dffssr_pipe.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dffssr_pipe_if.sv
// Bus bundle for dffssr_pipe: functional, scan and toggle-count controls in; pipeline outputs back.
// WIDTH and CNT_W must match the parameters of the attached dffssr_pipe instance.
interface dffssr_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] D;
    logic             VLD_IN;
    logic             EN;
    logic             SETB;
    logic             RSTB;
    logic             SE;
    logic             SI;
    logic             TGL_EN;
    logic             TGL_CLR;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QN;
    logic             VLD_OUT;
    logic             SO;
    logic [CNT_W-1:0] TGL_CNT;

    modport master (
        output D, VLD_IN, EN, SETB, RSTB, SE, SI, TGL_EN, TGL_CLR,
        input  Q, QN, VLD_OUT, SO, TGL_CNT
    );

    modport slave (
        input  D, VLD_IN, EN, SETB, RSTB, SE, SI, TGL_EN, TGL_CLR,
        output Q, QN, VLD_OUT, SO, TGL_CNT
    );
endinterface

// File: rtl/dffssr_pipe.sv
// DEPTH-stage, WIDTH-bit register pipeline with sync set/reset, clock enable, full scan chain,
// async reset and a saturating toggle counter on the output stage.
module dffssr_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input logic          CLK,
    input logic          RST,
    dffssr_pipe_if.slave bus
);
    localparam int unsigned N     = WIDTH * DEPTH;
    localparam int unsigned PC_W  = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_SHIFT,
        ACT_SET,
        ACT_CLR,
        ACT_SCAN
    } act_t;

    act_t                        w_act;
    logic [DEPTH-1:0][WIDTH-1:0] r_stage;
    logic [DEPTH-1:0][WIDTH-1:0] w_stage_nxt;
    logic [DEPTH-1:0]            r_vld;
    logic [DEPTH-1:0]            w_vld_nxt;
    logic [N-1:0]                w_chain;
    logic [N-1:0]                w_chain_sh;
    logic [PC_W-1:0]             w_tgl;
    logic [ACC_W-1:0]            w_acc;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_nxt;

    always_comb begin
        w_act = ACT_HOLD;
        if (bus.SE) begin
            w_act = ACT_SCAN;
        end else if (!bus.SETB) begin
            w_act = ACT_SET;
        end else if (!bus.RSTB) begin
            w_act = ACT_CLR;
        end else if (bus.EN) begin
            w_act = ACT_SHIFT;
        end
    end

    // Flattened packed array puts stage0[0] at bit 0, so the scan chain is a plain left shift.
    assign w_chain = r_stage;

    always_comb begin
        w_chain_sh    = '0;
        w_chain_sh[0] = bus.SI;
        for (int unsigned k = 1; k < N; k++) begin
            w_chain_sh[k] = w_chain[k-1];
        end
    end

    always_comb begin
        w_stage_nxt = r_stage;
        w_vld_nxt   = r_vld;
        unique case (w_act)
            ACT_SCAN: begin
                w_stage_nxt = w_chain_sh;
            end
            ACT_SET: begin
                w_stage_nxt = '1;
                w_vld_nxt   = '0;
            end
            ACT_CLR: begin
                w_stage_nxt = '0;
                w_vld_nxt   = '0;
            end
            ACT_SHIFT: begin
                w_stage_nxt[0] = bus.D;
                w_vld_nxt[0]   = bus.VLD_IN;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    w_stage_nxt[i] = r_stage[i-1];
                    w_vld_nxt[i]   = r_vld[i-1];
                end
            end
            default: begin
            end
        endcase
    end

    // Toggles are counted on the output stage's next value, so every action source is included.
    always_comb begin
        w_tgl = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            w_tgl = w_tgl + PC_W'(w_stage_nxt[DEPTH-1][b] ^ r_stage[DEPTH-1][b]);
        end
    end

    assign w_acc = ACC_W'(r_cnt) + ACC_W'(w_tgl);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.TGL_CLR) begin
            w_cnt_nxt = '0;
        end else if (bus.TGL_EN) begin
            if (|w_acc[ACC_W-1:CNT_W]) begin
                w_cnt_nxt = '1;
            end else begin
                w_cnt_nxt = w_acc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stage <= '0;
            r_vld   <= '0;
            r_cnt   <= '0;
        end else begin
            r_stage <= w_stage_nxt;
            r_vld   <= w_vld_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.Q       = r_stage[DEPTH-1];
    assign bus.QN      = ~r_stage[DEPTH-1];
    assign bus.VLD_OUT = r_vld[DEPTH-1];
    assign bus.SO      = r_stage[DEPTH-1][WIDTH-1];
    assign bus.TGL_CNT = r_cnt;
endmodule
